// File: rtl/instr_sequencer.sv
//------------------------------------------------------------------------------
// Module   : instr_sequencer
// Brief    : Multi-cycle stage controller. Sequences PC fetch, instruction
//            fetch, register read, execute, serialized write-backs and PC
//            write-back. Optional performance counters: SEQ_PERF_CNT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instr_sequencer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             mem_ready,
   input  logic             reg_wb_en,
   input  logic             mem_wb_en,
   input  logic             flag_wb_en,
   output logic             PC_fetch,
   output logic             fetch_tr,
   output logic             reg_tr,
   output logic             dne_tr,
   output logic             reg_wb_tr,
   output logic             mem_wb_tr,
   output logic             flag_update_tr,
   output logic             PC_wb_tr,
   output logic             busy,
   output logic [1:0]       wb_count,
   output logic [WIDTH-1:0] cycle_count,
   output logic [WIDTH-1:0] instr_count
);

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_PCF     = 4'd1,
      S_FETCH   = 4'd2,
      S_REG     = 4'd3,
      S_EXEC    = 4'd4,
      S_CHECK   = 4'd5,
      S_WB_REG  = 4'd6,
      S_WB_MEM  = 4'd7,
      S_WB_FLAG = 4'd8,
      S_PCWB    = 4'd9
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [2:0] r_pending;      // {reg, mem, flag}
   logic [2:0] w_pending_nxt;
   logic [1:0] r_wb_count;
   logic [1:0] w_wb_count_nxt;

   // First outstanding write-back in fixed priority order, else PC write-back
   function automatic state_t f_first_pending(input logic [2:0] mask);
      if (mask[2])      return S_WB_REG;
      else if (mask[1]) return S_WB_MEM;
      else if (mask[0]) return S_WB_FLAG;
      else              return S_PCWB;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_pending  <= 3'b000;
         r_wb_count <= 2'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_pending  <= w_pending_nxt;
         r_wb_count <= w_wb_count_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_pending_nxt  = r_pending;
      w_wb_count_nxt = r_wb_count;
      case (r_state)
         S_IDLE:    if (run) w_state_nxt = S_PCF;
         S_PCF:     w_state_nxt = S_FETCH;
         S_FETCH:   if (mem_ready) w_state_nxt = S_REG;
         S_REG:     w_state_nxt = S_EXEC;
         S_EXEC:    w_state_nxt = S_CHECK;
         S_CHECK: begin
            w_pending_nxt  = {reg_wb_en, mem_wb_en, flag_wb_en};
            w_wb_count_nxt = {1'b0, reg_wb_en} + {1'b0, mem_wb_en} + {1'b0, flag_wb_en};
            w_state_nxt    = f_first_pending(w_pending_nxt);
         end
         S_WB_REG: begin
            w_pending_nxt = r_pending & 3'b011;
            w_state_nxt   = f_first_pending(w_pending_nxt);
         end
         S_WB_MEM: begin
            if (mem_ready) begin
               w_pending_nxt = r_pending & 3'b001;
               w_state_nxt   = f_first_pending(w_pending_nxt);
            end
         end
         S_WB_FLAG: begin
            w_pending_nxt = 3'b000;
            w_state_nxt   = S_PCWB;
         end
         S_PCWB:    w_state_nxt = run ? S_PCF : S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   assign PC_fetch       = (r_state == S_PCF);
   assign fetch_tr       = (r_state == S_FETCH);
   assign reg_tr         = (r_state == S_REG);
   assign dne_tr         = (r_state == S_EXEC);
   assign reg_wb_tr      = (r_state == S_WB_REG);
   assign mem_wb_tr      = (r_state == S_WB_MEM);
   assign flag_update_tr = (r_state == S_WB_FLAG);
   assign PC_wb_tr       = (r_state == S_PCWB);
   assign busy           = (r_state != S_IDLE);
   assign wb_count       = r_wb_count;

`ifdef SEQ_PERF_CNT_EN
   logic [WIDTH-1:0] r_cycle_count;
   logic [WIDTH-1:0] r_instr_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cycle_count <= '0;
         r_instr_count <= '0;
      end else begin
         if (r_state != S_IDLE) r_cycle_count <= r_cycle_count + 1'b1;
         if (r_state == S_PCWB) r_instr_count <= r_instr_count + 1'b1;
      end
   end

   assign cycle_count = r_cycle_count;
   assign instr_count = r_instr_count;
`else
   assign cycle_count = '0;
   assign instr_count = '0;
`endif

endmodule

`default_nettype wire

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle stage controller for the CPU core. It replaces the free-running trigger chain with a single explicit state machine that sequences PC fetch, instruction fetch, register read, decode/execute, serialized write-backs and PC write-back. It sits between the top-level clock/run control and the program counter, memory, register file and execute units, driving their existing trigger inputs. Write-backs are issued one at a time in a fixed order, and memory accesses wait on a ready handshake.

## Interface
- WIDTH, 16, width of the performance counters (matches `WORD)
- clk  in  1  system clock, all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  level; 1 = issue instructions, 0 = stop at next instruction boundary
- mem_ready  in  1  memory can accept fetch/write-back this cycle
- reg_wb_en  in  1  execute requests register write-back; sampled in CHECK
- mem_wb_en  in  1  execute requests memory write-back; sampled in CHECK
- flag_wb_en  in  1  execute requests SREG update; sampled in CHECK
- PC_fetch  out  1  high in state PCF
- fetch_tr  out  1  high in state FETCH
- reg_tr  out  1  high in state REG
- dne_tr  out  1  high in state EXEC
- reg_wb_tr  out  1  high in state WB_REG
- mem_wb_tr  out  1  high in state WB_MEM
- flag_update_tr  out  1  high in state WB_FLAG
- PC_wb_tr  out  1  high in state PCWB
- busy  out  1  high in every state except IDLE
- wb_count  out  2  number of write-backs latched in the most recent CHECK
- cycle_count  out  WIDTH  non-IDLE cycles (see Configuration)
- instr_count  out  WIDTH  retired instructions (see Configuration)

## Operation
- Registered state, 4 bits. States: IDLE, PCF, FETCH, REG, EXEC, CHECK, WB_REG, WB_MEM, WB_FLAG, PCWB.
- Trigger outputs are a pure decode of the state. Exactly one trigger is high in any non-IDLE, non-CHECK state. None is high in IDLE or CHECK.
- Reset (rst_n=0, asynchronous): state=IDLE, pending mask=000, wb_count=0, counters=0. All outputs are 0.
- Transitions:
  - IDLE -> PCF when run=1; otherwise stays in IDLE.
  - PCF -> FETCH.
  - FETCH holds while mem_ready=0, with fetch_tr held high. It goes to REG when mem_ready=1.
  - REG -> EXEC -> CHECK.
  - CHECK latches pending = {reg_wb_en, mem_wb_en, flag_wb_en} and sets wb_count to the popcount of that mask. It goes to the first pending state in the order WB_REG, WB_MEM, WB_FLAG, or to PCWB if none are pending.
  - WB_REG takes 1 cycle, clears its pending bit, and goes to the next pending state or PCWB.
  - WB_MEM holds while mem_ready=0. On mem_ready=1 it clears its bit and advances.
  - WB_FLAG takes 1 cycle, clears its bit, and advances.
  - PCWB -> PCF if run=1, else IDLE.
- Write-back enables are only sampled in CHECK. Changes to them during the WB_* states are ignored.
- run=0 mid-instruction does not abort. The instruction completes through PCWB, then the block enters IDLE.
- Reset asserted mid-instruction abandons the instruction immediately. No further triggers are issued.

## Timing
- Minimum instruction, with no write-backs and mem_ready=1: 6 cycles (PCF, FETCH, REG, EXEC, CHECK, PCWB).
- Each write-back adds 1 cycle, plus one cycle per wait cycle with mem_ready=0 in WB_MEM. All three write-backs give 9 cycles.
- Each FETCH wait cycle adds 1 cycle.
- The first PC_fetch is high on the cycle after the first rising edge at which run=1 in IDLE.
- Back-to-back instructions: PCWB is followed directly by PCF, with no idle bubble.

## Configuration
- SEQ_PERF_CNT_EN defined:
  - cycle_count increments on every clock where state != IDLE.
  - instr_count increments on every clock in PCWB.
  - Both counters wrap modulo 2^WIDTH.
  - Both are cleared only by reset.
- SEQ_PERF_CNT_EN undefined: no counter registers are built, and cycle_count and instr_count are tied to 0.

## Test plan
- Reset, then run=1, mem_ready=1, all wb_en=0: the sequence PCF, FETCH, REG, EXEC, CHECK, PCWB repeats every 6 cycles. wb_count=0. After 3 instructions, instr_count=3 and cycle_count=18.
- reg_wb_en=mem_wb_en=flag_wb_en=1 at CHECK: reg_wb_tr, mem_wb_tr and flag_update_tr pulse on consecutive cycles in that order, then PC_wb_tr. wb_count=3 and the instruction takes 9 cycles.
- mem_ready=0 for 2 cycles in FETCH and for 3 cycles in WB_MEM (mem_wb_en only): fetch_tr is high for 3 cycles and mem_wb_tr for 4. The instruction takes 12 cycles.
- Drop run to 0 during REG: the instruction completes through PCWB and the block enters IDLE with busy=0. No PC_fetch follows.
- Assert rst_n=0 in WB_MEM: all outputs are 0 immediately, without waiting for a clock edge. Release rst_n with run=1: a fresh PCF starts and the counters restart from 0.
- With SEQ_PERF_CNT_EN and WIDTH=4, run 3 instructions: cycle_count wraps from 15 to 0 and reads 2 after 18 non-IDLE cycles. Without SEQ_PERF_CNT_EN, both counters read 0 throughout.
